// File: rtl/note_player_pkg.sv
// Shared types and colour lookup for the note_player sequence playback block.
package note_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef logic [1:0] colour_t;

    localparam logic [9:0] FREQ_C0 = 10'd415;
    localparam logic [9:0] FREQ_C1 = 10'd310;
    localparam logic [9:0] FREQ_C2 = 10'd252;
    localparam logic [9:0] FREQ_C3 = 10'd209;

    localparam logic [3:0] LED_C0 = 4'b0001;
    localparam logic [3:0] LED_C1 = 4'b0010;
    localparam logic [3:0] LED_C2 = 4'b0100;
    localparam logic [3:0] LED_C3 = 4'b1000;

    function automatic logic [9:0] freq_of_colour(colour_t c);
        case (c)
            2'd0:    freq_of_colour = FREQ_C0;
            2'd1:    freq_of_colour = FREQ_C1;
            2'd2:    freq_of_colour = FREQ_C2;
            default: freq_of_colour = FREQ_C3;
        endcase
    endfunction

    function automatic logic [3:0] led_of_colour(colour_t c);
        case (c)
            2'd0:    led_of_colour = LED_C0;
            2'd1:    led_of_colour = LED_C1;
            2'd2:    led_of_colour = LED_C2;
            default: led_of_colour = LED_C3;
        endcase
    endfunction

endpackage

// File: rtl/note_player_ms_timer.sv
// Millisecond interval timer: counts T = max(ticks_per_milli,1) cycles per ms and
// pulses expire on the final cycle of a target_ms long interval, then rearms itself.
module ms_timer #(
    parameter int MSW = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           restart,
    input  logic           run,
    input  logic [15:0]    ticks_per_milli,
    input  logic [MSW-1:0] target_ms,
    output logic           expire
);

    logic [15:0]    tpm;
    logic [15:0]    cyc_q, cyc_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic [MSW:0]   ms_next;
    logic           last_cyc;

    always_comb begin
        tpm      = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
        // >= keeps the counter bounded if ticks_per_milli shrinks mid-interval
        last_cyc = (cyc_q >= tpm - 16'd1);
        ms_next  = {1'b0, ms_q} + {{MSW{1'b0}}, 1'b1};
        expire   = run && last_cyc && (ms_next >= {1'b0, target_ms});

        cyc_d = cyc_q;
        ms_d  = ms_q;
        if (restart || !run || expire) begin
            cyc_d = 16'd0;
            ms_d  = '0;
        end else if (last_cyc) begin
            cyc_d = 16'd0;
            ms_d  = ms_next[MSW-1:0];
        end else begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 16'd0;
            ms_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/note_player.sv
// Colour-sequence note player: records colours, then plays them as timed tones with gaps.
// Optional NOTE_PLAYER_SPEEDUP_EN shortens notes as the stored sequence grows.
module note_player
    import note_player_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int NOTE_MS = 400,
    parameter int GAP_MS  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        wr_en,
    input  logic [1:0]  wr_color,
    input  logic        clear,
    input  logic        start,
    output logic [9:0]  frequency,
    output logic [3:0]  color_led,
    output logic        busy,
    output logic        done,
    output logic [6:0]  count,
    output logic        full,
    output state_t      dbg_state
);

    localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MAX_MS = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
    localparam int MSW    = $clog2(MAX_MS + 1);

    state_t         state_q, state_d;
    logic [6:0]     count_q, count_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [9:0]     freq_q, freq_d;
    logic [3:0]     led_q, led_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    colour_t        buf_q [MAX_LEN];

    logic           wr_ok, more, run, expire;
    logic [MSW-1:0] note_ms, target_ms;

`ifdef NOTE_PLAYER_SPEEDUP_EN
    always_comb begin
        if (count_q <= 7'd5)       note_ms = MSW'(NOTE_MS);
        else if (count_q <= 7'd13) note_ms = MSW'(3 * NOTE_MS / 4);
        else                       note_ms = MSW'(NOTE_MS / 2);
    end
`else
    assign note_ms = MSW'(NOTE_MS);
`endif

    // Handshake: wr_en and start are single-cycle requests with no ready; wr_en is
    // accepted only when !full && !busy && !clear, start only when !busy && !clear.
    assign wr_ok     = wr_en && !clear && !full && !busy_q;
    assign full      = (count_q == 7'(MAX_LEN));
    assign run       = (state_q == NOTE) || (state_q == GAP);
    assign target_ms = (state_q == NOTE) ? note_ms : MSW'(GAP_MS);
    assign more      = (7'(idx_q) + 7'd1) < count_q;

    ms_timer #(.MSW(MSW)) u_timer (
        .clk             (clk),
        .rst             (rst),
        .restart         (clear),
        .run             (run),
        .ticks_per_milli (ticks_per_milli),
        .target_ms       (target_ms),
        .expire          (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;

        case (state_q)
            IDLE: if (start) begin
                state_d = (count_q != 7'd0) ? NOTE : FIN;
                idx_d   = '0;
            end
            NOTE: if (expire) state_d = more ? GAP : FIN;
            GAP:  if (expire) begin
                state_d = NOTE;
                idx_d   = idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
            count_d = 7'd0;
        end else if (wr_ok) begin
            count_d = count_q + 7'd1;
        end

        // Outputs are registered from the next state so they line up with state_q.
        freq_d = (state_d == NOTE) ? freq_of_colour(buf_q[idx_d]) : 10'd0;
        led_d  = (state_d == NOTE) ? led_of_colour(buf_q[idx_d]) : 4'd0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 7'd0;
            idx_q   <= '0;
            freq_q  <= 10'd0;
            led_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            freq_q  <= freq_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) buf_q[count_q[IW-1:0]] <= wr_color;
    end

    assign frequency = freq_q;
    assign color_led = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: playback traces are queued per cycle and checked by a monitor.
module tb_note_player;
    import note_player_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int NOTE_MS = 4;
    localparam int GAP_MS  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ticks_per_milli;
    logic        wr_en;
    logic [1:0]  wr_color;
    logic        clear;
    logic        start;
    logic [9:0]  frequency;
    logic [3:0]  color_led;
    logic        busy;
    logic        done;
    logic [6:0]  count;
    logic        full;
    state_t      dbg_state;

    logic [14:0] exp_q[$];
    logic [1:0]  seq[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_seen = 0;

    note_player #(.MAX_LEN(MAX_LEN), .NOTE_MS(NOTE_MS), .GAP_MS(GAP_MS)) dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .wr_en           (wr_en),
        .wr_color        (wr_color),
        .clear           (clear),
        .start           (start),
        .frequency       (frequency),
        .color_led       (color_led),
        .busy            (busy),
        .done            (done),
        .count           (count),
        .full            (full),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference colour map
    function automatic logic [9:0] tone(logic [1:0] c);
        case (c)
            2'd0:    tone = 10'd415;
            2'd1:    tone = 10'd310;
            2'd2:    tone = 10'd252;
            default: tone = 10'd209;
        endcase
    endfunction

    function automatic logic [3:0] lamp(logic [1:0] c);
        case (c)
            2'd0:    lamp = 4'b0001;
            2'd1:    lamp = 4'b0010;
            2'd2:    lamp = 4'b0100;
            default: lamp = 4'b1000;
        endcase
    endfunction

    function automatic int note_ms_for(int n);
`ifdef NOTE_PLAYER_SPEEDUP_EN
        if (n <= 5)       note_ms_for = NOTE_MS;
        else if (n <= 13) note_ms_for = 3 * NOTE_MS / 4;
        else              note_ms_for = NOTE_MS / 2;
`else
        note_ms_for = NOTE_MS;
`endif
    endfunction

    function automatic int t_of(logic [15:0] tpm);
        t_of = (tpm == 16'd0) ? 1 : int'(tpm);
    endfunction

    // scoreboard: push the full per-cycle trace of a complete playback of seq
    task automatic push_play();
        int n  = seq.size();
        int nc = note_ms_for(n) * t_of(ticks_per_milli);
        int gc = GAP_MS * t_of(ticks_per_milli);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < nc; k++) exp_q.push_back({tone(seq[i]), lamp(seq[i]), 1'b0});
            if (i < n - 1)
                for (int k = 0; k < gc; k++) exp_q.push_back(15'd0);
        end
        exp_q.push_back({10'd0, 4'd0, 1'b1});
    endtask

    task automatic push_cycles(logic [1:0] c, bit sounding, int cycles);
        for (int k = 0; k < cycles; k++)
            exp_q.push_back(sounding ? {tone(c), lamp(c), 1'b0} : 15'd0);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_wr(logic [1:0] c);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_color = c;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wr(logic [1:0] c);
        drive_wr(c);
        if (seq.size() < MAX_LEN) seq.push_back(c);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        seq.delete();
    endtask

    task automatic wait_idle(string name, int budget);
        int k = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, (k < budget) ? 32'd0 : 32'd1, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // monitor: every cycle the DUT is busy or pulses done is one trace entry
    always @(negedge clk) begin
        if (busy === 1'b1 || done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL play_trace[%0d]: got freq=%0d led=%b done=%b, expected no activity",
                         n_seen, frequency, color_led, done);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({frequency, color_led, done} !== e) begin
                    n_fail++;
                    $display("FAIL play_trace[%0d]: got freq=%0d led=%b done=%b, expected freq=%0d led=%b done=%b",
                             n_seen, frequency, color_led, done, e[14:5], e[4:1], e[0]);
                end
            end
            n_seen++;
        end
    end

    initial begin
        rst = 1'b1; ticks_per_milli = 16'd2;
        wr_en = 1'b0; wr_color = 2'd0; clear = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {frequency, color_led, busy, done, full}, 0);
        check("reset_count", count, 0);

        // three-note sequence 2,0,3 with exact durations; writes/start while busy ignored
        wr(2'd2); wr(2'd0); wr(2'd3);
        @(negedge clk);
        check("count_after_3_writes", count, 3);
        push_play();
        pulse_start();
        drive_wr(2'd1);
        pulse_start();
        @(negedge clk);
        check("count_write_while_busy", count, 3);
        wait_idle("play_3_timeout", 200);

        // start with an empty buffer
        do_clear();
        @(negedge clk);
        check("count_after_clear", count, 0);
        push_play();
        pulse_start();
        wait_idle("empty_start_timeout", 20);

        // clear during the second note: silent and idle next cycle, no done
        wr(2'd1); wr(2'd3);
        push_cycles(2'd1, 1'b1, 8);
        push_cycles(2'd0, 1'b0, 4);
        push_cycles(2'd3, 1'b1, 3);
        pulse_start();
        repeat (14) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        seq.delete();
        @(negedge clk);
        check("clear_busy", busy, 0);
        check("clear_freq", frequency, 0);
        check("clear_count", count, 0);
        repeat (5) @(posedge clk);
        check("clear_trace_drained", exp_q.size(), 0);

        // clear wins over start and over wr_en
        wr(2'd0);
        @(posedge clk); #1 clear = 1'b1; start = 1'b1;
        @(posedge clk); #1 clear = 1'b0; start = 1'b0;
        seq.delete();
        @(negedge clk);
        check("clear_start_busy", busy, 0);
        check("clear_start_count", count, 0);
        @(posedge clk); #1 clear = 1'b1; wr_en = 1'b1; wr_color = 2'd2;
        @(posedge clk); #1 clear = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("clear_wr_count", count, 0);

        // fill to MAX_LEN, 33rd write dropped, then play all 32
        ticks_per_milli = 16'd1;
        for (int i = 0; i < 33; i++) begin
            wr(2'((i * 3 + 1) % 4));
            if (i == 30) begin
                @(negedge clk);
                check("count_31", count, 31);
                check("full_at_31", full, 0);
            end
        end
        @(negedge clk);
        check("count_full", count, MAX_LEN);
        check("full_flag", full, 1);
        push_play();
        pulse_start();
        wait_idle("play_32_timeout", 600);

        // reset mid-gap with ticks_per_milli=0 (acts as 1), then fresh playback
        ticks_per_milli = 16'd0;
        do_clear();
        wr(2'd0); wr(2'd1);
        push_cycles(2'd0, 1'b1, 4);
        push_cycles(2'd0, 1'b0, 1);
        pulse_start();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seq.delete();
        @(negedge clk);
        check("rst_mid_outputs", {frequency, color_led, busy, done}, 0);
        check("rst_mid_count", count, 0);
        check("rst_trace_drained", exp_q.size(), 0);
        wr(2'd3); wr(2'd2);
        push_play();
        pulse_start();
        wait_idle("play_after_rst_timeout", 100);

        // 14 entries: note length depends on the speedup build option
        ticks_per_milli = 16'd1;
        do_clear();
        for (int i = 0; i < 14; i++) wr(2'(i % 4));
        push_play();
        pulse_start();
        wait_idle("play_14_timeout", 300);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
